dat_xfer_ctrl: RTL
==================

# dat_xfer_ctrl

Sequencer that drives the DAT-line word transfer stage of the SD host. For each block it fetches or stores 32-bit words in the data FIFO, counts words per block and blocks per transfer, waits for the card start bit on reads with a timeout, and inserts the inter-block gap. It sits directly upstream of the DAT serializer/deserializer stage: it drives that stage's enable, width and direction lines and consumes its completion acks.

## Interface
- BLOCK_WORDS_W, 10, width of the words-per-block field (max 1023 words)
- BLOCK_CNT_W, 16, width of the block-count field
- TIMEOUT, 1024, cycles to wait for the read start bit before flagging a timeout
- GAP_CYCLES, 8, idle cycles between consecutive blocks

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- abort  in  1  synchronous abort; valid in any non-IDLE state
- direction  in  1  1 = card to buffer (read), 0 = buffer to card (write)
- width_4bit  in  1  1 = 4-bit DAT, 0 = 1-bit DAT
- multi_block  in  1  1 = use block_count, 0 = exactly one block
- block_words  in  BLOCK_WORDS_W  words per block; 0 is treated as 1
- block_count  in  BLOCK_CNT_W  blocks per transfer; 0 is treated as 1
- card_start  in  1  DAT0 start-bit detect (active high, from the line sampler)
- fifo_empty  in  1  data FIFO empty (write path)
- fifo_full  in  1  data FIFO full (read path)
- ack_card  in  1  word fully shifted to the card
- ack_buff  in  1  word fully assembled from the card
- trans_enable  out  1  enable to the word stage
- mode_o  out  1  latched width_4bit
- dir_o  out  1  latched direction
- fifo_rd  out  1  one-cycle pop (write path)
- fifo_wr  out  1  one-cycle push (read path)
- blocks_done  out  BLOCK_CNT_W  completed-block count
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on successful completion
- timeout_err  out  1  sticky until the next accepted start

## Operation
- On reset, all outputs and counters are 0 and the state is IDLE.
- IDLE: when start=1, latch direction, width_4bit, the effective block_words and the effective block count (1 if multi_block=0). Clear the word and block counters and timeout_err. Go to WAIT.
- WAIT, write path: when fifo_empty=0, assert fifo_rd for one cycle and go to XFER.
- WAIT, read path, first word of a block: the timeout counter counts up each cycle. When card_start=1, go to XFER. When the count reaches TIMEOUT-1 with no start bit, set timeout_err and go to IDLE. done is not pulsed.
- WAIT, read path, later words of a block: go to XFER immediately.
- XFER: trans_enable=1. Hold until the ack (ack_card when dir_o=0, ack_buff when dir_o=1) is seen. Then go to WORD.
- WORD, read path: if fifo_full=1, stall in WORD with fifo_wr=0. Otherwise pulse fifo_wr.
- WORD, then the word counter increments:
  - if the counter has not reached block_words-1, go to WAIT;
  - otherwise clear the word counter, increment blocks_done and go to GAP.
- GAP: count GAP_CYCLES cycles. Then go to DONE if blocks_done equals the latched count, otherwise go to WAIT.
- DONE: pulse done for one cycle, then go to IDLE.
- abort: from any non-IDLE state, go to IDLE on the next edge. trans_enable drops and no done pulse is issued. blocks_done keeps its value.
- start is ignored while busy=1.
- Counters never wrap. The word counter compares against block_words-1. A block count of 2^BLOCK_CNT_W-1 is legal.

## Timing
- start high at edge N: busy=1 from N+1, and the WAIT decision is made in the cycle after N+1.
- Write word: the fifo_rd pulse is followed by trans_enable the next cycle, because FIFO data is valid one cycle after the pop.
- trans_enable stays high from entry to XFER through the cycle in which the ack is sampled high, and drops on the following edge.
- Ack-to-push latency: fifo_wr is asserted the cycle after the ack if the FIFO is not full.
- blocks_done updates on the same edge that enters GAP.
- done rises exactly GAP_CYCLES+1 cycles after the last word's WORD cycle.
- Asynchronous reset mid-transfer immediately forces the reset values, including trans_enable=0.
- If abort and the ack occur in the same cycle, abort wins.

## Test plan
- Single-block write: block_words=4, multi_block=0, FIFO never empty, ack_card 3 cycles after each enable -> exactly 4 fifo_rd pulses, blocks_done=1, one done pulse, busy returns to 0.
- Multi-block read: block_words=2, block_count=3, direction=1, card_start=1 after 5 cycles per block -> 6 fifo_wr pulses, GAP of 8 cycles between blocks, blocks_done=3, done pulse.
- Read timeout: card_start held 0 with TIMEOUT=16 -> timeout_err=1 after 16 WAIT cycles, no done pulse, state IDLE; the next start clears timeout_err.
- FIFO backpressure: read with fifo_full=1 for 10 cycles after an ack -> fifo_wr delayed until fifo_full=0, no word lost, final count correct.
- Abort mid-XFER on block 2 of 4 -> trans_enable=0 next cycle, blocks_done=1 retained, no done pulse; a new start is accepted.
- Zero fields: block_words=0, block_count=0, multi_block=1 -> behaves as 1 word × 1 block; also assert reset mid-transfer and check all outputs are 0 immediately.

Source files
------------

// File: rtl/dat_xfer_ctrl.sv
// rtl/dat_xfer_ctrl.sv - DAT-line word transfer sequencer for the SD host data path
module dat_xfer_ctrl #(
    parameter int BLOCK_WORDS_W = 10,
    parameter int BLOCK_CNT_W   = 16,
    parameter int TIMEOUT       = 1024,
    parameter int GAP_CYCLES    = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     direction,
    input  logic                     width_4bit,
    input  logic                     multi_block,
    input  logic [BLOCK_WORDS_W-1:0] block_words,
    input  logic [BLOCK_CNT_W-1:0]   block_count,
    input  logic                     card_start,
    input  logic                     fifo_empty,
    input  logic                     fifo_full,
    input  logic                     ack_card,
    input  logic                     ack_buff,
    output logic                     trans_enable,
    output logic                     mode_o,
    output logic                     dir_o,
    output logic                     fifo_rd,
    output logic                     fifo_wr,
    output logic [BLOCK_CNT_W-1:0]   blocks_done,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout_err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_XFER = 3'd2;
    localparam logic [2:0] S_WORD = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    logic [2:0]               state;
    logic [BLOCK_WORDS_W-1:0] word_cnt;
    logic [BLOCK_WORDS_W-1:0] last_word;   // effective block_words minus one
    logic [BLOCK_CNT_W-1:0]   blk_total;   // effective block count
    logic [TO_W-1:0]          to_cnt;
    logic [GAP_W-1:0]         gap_cnt;
    logic                     ack_sel;
    logic                     aborting;

    assign ack_sel  = dir_o ? ack_buff : ack_card;
    assign aborting = abort && (state != S_IDLE);

    // Strobes are decoded from state so an asynchronous reset drops them at once;
    // abort suppresses any strobe in the cycle it is seen.
    assign trans_enable = (state == S_XFER);
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE) && !abort;
    assign fifo_rd      = (state == S_WAIT) && !dir_o && !fifo_empty && !abort;
    assign fifo_wr      = (state == S_WORD) && dir_o && !fifo_full && !abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            word_cnt    <= '0;
            last_word   <= '0;
            blk_total   <= '0;
            to_cnt      <= '0;
            gap_cnt     <= '0;
            mode_o      <= 1'b0;
            dir_o       <= 1'b0;
            blocks_done <= '0;
            timeout_err <= 1'b0;
        end else if (aborting) begin
            // blocks_done is deliberately left as-is so software can see progress.
            state    <= S_IDLE;
            word_cnt <= '0;
            to_cnt   <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_o      <= width_4bit;
                        dir_o       <= direction;
                        last_word   <= (block_words == '0) ? '0 : block_words - BLOCK_WORDS_W'(1);
                        blk_total   <= (!multi_block || block_count == '0) ? BLOCK_CNT_W'(1) : block_count;
                        word_cnt    <= '0;
                        blocks_done <= '0;
                        timeout_err <= 1'b0;
                        to_cnt      <= '0;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!dir_o) begin
                        if (!fifo_empty) state <= S_XFER;
                    end else if (word_cnt != '0) begin
                        // Start bit only precedes the first word of a block.
                        state <= S_XFER;
                    end else if (card_start) begin
                        to_cnt <= '0;
                        state  <= S_XFER;
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        to_cnt      <= '0;
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                S_XFER: begin
                    if (ack_sel) state <= S_WORD;
                end
                S_WORD: begin
                    if (!(dir_o && fifo_full)) begin
                        if (word_cnt == last_word) begin
                            word_cnt    <= '0;
                            blocks_done <= blocks_done + BLOCK_CNT_W'(1);
                            gap_cnt     <= '0;
                            state       <= S_GAP;
                        end else begin
                            word_cnt <= word_cnt + BLOCK_WORDS_W'(1);
                            state    <= S_WAIT;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        gap_cnt <= '0;
                        state   <= (blocks_done == blk_total) ? S_DONE : S_WAIT;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
